// File: rtl/pedestrian_xing.sv
// Pedestrian crossing controller: synchronised, debounced request button,
// timed car/pedestrian phases and a night-time flashing-yellow mode.
module pedestrian_xing #(
    parameter int unsigned TIMER_SCALE = 16000000,
    parameter int unsigned T_GREEN_MIN = 10,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALL_RED   = 2,
    parameter int unsigned T_PED_GREEN = 8,
    parameter int unsigned T_PED_CLEAR = 4,
    parameter int unsigned DB_CYCLES   = 160000
) (
    input  logic i_pin3_clk_16mhz,
    input  logic i_pin2_rst_n,
    input  logic i_pin9_ped_button,
    input  logic i_pin10_flash_mode,
    output logic o_pin4_green,
    output logic o_pin5_yellow,
    output logic o_pin6_red,
    output logic o_pin7_ped_green,
    output logic o_pin8_ped_red,
    output logic o_pin11_wait_lamp
);

    localparam int PW  = $clog2(TIMER_SCALE + 1);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int PHW = $clog2(T_GREEN_MIN + T_YELLOW + T_ALL_RED
                                + T_PED_GREEN + T_PED_CLEAR + 1);

    typedef enum logic [2:0] {
        ALL_RED_B, CAR_GREEN, CAR_YELLOW, ALL_RED_A,
        PED_GREEN, PED_CLEAR, FLASH
    } state_e;

    state_e           state_q, state_d;
    logic             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic             fm_s1_q, fm_s1_d, fm_s2_q, fm_s2_d;
    logic [DBW-1:0]   db_cnt_q, db_cnt_d;
    logic             db_level_q, db_level_d;
    logic             req_q, req_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [PHW-1:0]   phase_q, phase_d;
    logic             blink_q, blink_d;
    logic             green_q, green_d, yellow_q, yellow_d, red_q, red_d;
    logic             ped_green_q, ped_green_d, ped_red_q, ped_red_d;
    logic             rise, tick, min_ok, entry;

    always_comb begin
        btn_s1_d = i_pin9_ped_button;
        btn_s2_d = btn_s1_q;
        fm_s1_d  = i_pin10_flash_mode;
        fm_s2_d  = fm_s1_q;

        // Count consecutive samples that disagree with the accepted level.
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (btn_s2_q != db_level_q) begin
            if (db_cnt_q == DBW'(DB_CYCLES - 1)) db_level_d = btn_s2_q;
            else db_cnt_d = db_cnt_q + 1'b1;
        end
        rise = db_level_d & ~db_level_q;

        tick   = (pre_q == PW'(TIMER_SCALE - 1));
        min_ok = (phase_q >= PHW'(T_GREEN_MIN))
                 || (tick && phase_q == PHW'(T_GREEN_MIN - 1));

        state_d = state_q;
        unique case (state_q)
            ALL_RED_B:
                if (tick && phase_q == PHW'(T_ALL_RED - 1)) state_d = CAR_GREEN;
            CAR_GREEN:
                if (fm_s2_q) state_d = FLASH;
                else if (req_q && min_ok) state_d = CAR_YELLOW;
            CAR_YELLOW:
                if (tick && phase_q == PHW'(T_YELLOW - 1)) state_d = ALL_RED_A;
            ALL_RED_A:
                if (tick && phase_q == PHW'(T_ALL_RED - 1)) state_d = PED_GREEN;
            PED_GREEN:
                if (tick && phase_q == PHW'(T_PED_GREEN - 1)) state_d = PED_CLEAR;
            PED_CLEAR:
                if (tick && phase_q == PHW'(T_PED_CLEAR - 1)) state_d = ALL_RED_B;
            FLASH:
                if (!fm_s2_q) state_d = ALL_RED_B;
            default: state_d = ALL_RED_B;
        endcase
        entry = (state_d != state_q);

        pre_d   = tick ? '0 : pre_q + 1'b1;
        phase_d = phase_q;
        blink_d = tick ? ~blink_q : blink_q;
        if (tick && state_q != FLASH) begin
            if (state_q != CAR_GREEN || phase_q < PHW'(T_GREEN_MIN))
                phase_d = phase_q + 1'b1;
        end
        if (entry) begin
            pre_d   = '0;
            phase_d = '0;
            blink_d = 1'b1;
        end

        req_d = req_q;
        if (rise && state_q != FLASH) req_d = 1'b1;
        if (entry && (state_d == PED_GREEN || state_d == FLASH)) req_d = 1'b0;

        green_d     = 1'b0;
        yellow_d    = 1'b0;
        red_d       = 1'b0;
        ped_green_d = 1'b0;
        ped_red_d   = 1'b0;
        unique case (state_d)
            CAR_GREEN:  begin green_d  = 1'b1; ped_red_d = 1'b1; end
            CAR_YELLOW: begin yellow_d = 1'b1; ped_red_d = 1'b1; end
            PED_GREEN:  begin red_d = 1'b1; ped_green_d = 1'b1; end
            PED_CLEAR:  begin red_d = 1'b1; ped_green_d = blink_d; end
            FLASH:      yellow_d = blink_d;
            default:    begin red_d = 1'b1; ped_red_d = 1'b1; end
        endcase
    end

    always_ff @(posedge i_pin3_clk_16mhz or negedge i_pin2_rst_n) begin
        if (!i_pin2_rst_n) begin
            state_q     <= ALL_RED_B;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            fm_s1_q     <= 1'b0;
            fm_s2_q     <= 1'b0;
            db_cnt_q    <= '0;
            db_level_q  <= 1'b0;
            req_q       <= 1'b0;
            pre_q       <= '0;
            phase_q     <= '0;
            blink_q     <= 1'b0;
            green_q     <= 1'b0;
            yellow_q    <= 1'b0;
            red_q       <= 1'b1;
            ped_green_q <= 1'b0;
            ped_red_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            fm_s1_q     <= fm_s1_d;
            fm_s2_q     <= fm_s2_d;
            db_cnt_q    <= db_cnt_d;
            db_level_q  <= db_level_d;
            req_q       <= req_d;
            pre_q       <= pre_d;
            phase_q     <= phase_d;
            blink_q     <= blink_d;
            green_q     <= green_d;
            yellow_q    <= yellow_d;
            red_q       <= red_d;
            ped_green_q <= ped_green_d;
            ped_red_q   <= ped_red_d;
        end
    end

    assign o_pin4_green      = green_q;
    assign o_pin5_yellow     = yellow_q;
    assign o_pin6_red        = red_q;
    assign o_pin7_ped_green  = ped_green_q;
    assign o_pin8_ped_red    = ped_red_q;
    assign o_pin11_wait_lamp = req_q;

endmodule

// File: tb/tb_pedestrian_xing.sv
// Directed bench for pedestrian_xing: phase table plus hand-written
// sequences for pedestrian-phase requests, flash mode and mid-phase reset.
module tb_pedestrian_xing;

    logic clk, rst_n, btn, fm;
    logic g, y, r, pg, pr, w;

    pedestrian_xing #(
        .TIMER_SCALE(1),
        .DB_CYCLES(4)
    ) dut (
        .i_pin3_clk_16mhz(clk),
        .i_pin2_rst_n(rst_n),
        .i_pin9_ped_button(btn),
        .i_pin10_flash_mode(fm),
        .o_pin4_green(g),
        .o_pin5_yellow(y),
        .o_pin6_red(r),
        .o_pin7_ped_green(pg),
        .o_pin8_ped_red(pr),
        .o_pin11_wait_lamp(w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {green, yellow, red, ped_green, ped_red, wait}
    localparam logic [5:0] L_RED = 6'b001010;
    localparam logic [5:0] L_GRN = 6'b100010;
    localparam logic [5:0] L_YEL = 6'b010010;
    localparam logic [5:0] L_PG  = 6'b001100;
    localparam logic [5:0] L_PC0 = 6'b001000;
    localparam logic [5:0] L_FY  = 6'b010000;
    localparam logic [5:0] L_OFF = 6'b000000;

    typedef struct {
        logic       btn;
        logic [5:0] exp;
        int         n;
        string      name;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [5:0] lamps();
        return {g, y, r, pg, pr, w};
    endfunction

    task automatic add(input logic b, input logic [5:0] e,
                       input int n, input string nm);
        vec_t v;
        v.btn = b; v.exp = e; v.n = n; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] exp);
        checks++;
        if (lamps() !== exp) begin
            failures++;
            $display("FAIL %s: lamps=%b required %b at %0t", nm, lamps(), exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_lamps(input logic [5:0] exp, input int budget,
                              input string nm, output int n);
        n = 0;
        while (lamps() !== exp && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (lamps() !== exp) begin
            failures++;
            $display("FAIL %s: timeout after %0d cycles, lamps=%b required %b",
                     nm, n, lamps(), exp);
        end
    endtask

    // Lamp exclusion must hold on every cycle of the run.
    always @(negedge clk) begin
        checks++;
        if ((g === 1'b1 && pg === 1'b1) || (pr === 1'b1 && pg === 1'b1)) begin
            failures++;
            $display("FAIL exclusion: green=%b ped_green=%b ped_red=%b required no overlap",
                     g, pg, pr);
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        btn   = 1'b0;
        fm    = 1'b0;

        add(0, L_RED,     1, "arb_after_rst");
        add(0, L_GRN,     4, "green");
        add(1, L_GRN,     5, "green_btn");
        add(1, L_GRN | 1, 1, "wait_set");
        add(0, L_YEL | 1, 3, "yellow");
        add(0, L_RED | 1, 2, "all_red_a");
        add(0, L_PG,      8, "ped_green");
        add(0, L_PG,      1, "pclr_1a");
        add(0, L_PC0,     1, "pclr_0a");
        add(0, L_PG,      1, "pclr_1b");
        add(0, L_PC0,     1, "pclr_0b");
        add(0, L_RED,     2, "all_red_b");
        add(0, L_GRN,     6, "green2");
        for (int k = 0; k < 4; k++) begin
            add(1, L_GRN, 3, "pulse_hi");
            add(0, L_GRN, 3, "pulse_lo");
        end
        add(0, L_GRN, 20, "green_hold");

        repeat (3) step();
        chk("reset", L_RED);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                btn = tbl[i].btn;
                step();
                chk(tbl[i].name, tbl[i].exp);
            end
        end
        btn = 1'b0;

        // Request during PED_GREEN is kept and served after a full minimum.
        btn = 1'b1;
        repeat (6) step();
        btn = 1'b0;
        chk("wait_sat", L_GRN | 1);
        wait_lamps(L_PG, 20, "to_ped_green", n);
        chk_int("ped_latency", n, 6);
        btn = 1'b1;
        repeat (6) step();
        btn = 1'b0;
        chk("wait_in_pg", L_PG | 1);
        wait_lamps(L_RED | 1, 20, "arb_wait", n);
        chk_int("arb_latency", n, 6);
        wait_lamps(L_GRN | 1, 5, "green_wait", n);
        chk_int("arb_len", n, 2);
        wait_lamps(L_YEL | 1, 20, "yellow_again", n);
        chk_int("green_min_rearm", n, 10);
        wait_lamps(L_GRN, 30, "cycle_back", n);
        chk_int("full_cycle", n, 19);

        // Flash mode overrides a pending request.
        btn = 1'b1;
        repeat (6) step();
        btn = 1'b0;
        chk("wait_pre_flash", L_GRN | 1);
        fm = 1'b1;
        wait_lamps(L_FY, 5, "to_flash", n);
        chk_int("flash_latency", n, 3);
        for (int i = 0; i < 8; i++) begin
            btn = (i < 6);
            step();
            chk("flash_toggle", (i % 2 == 0) ? L_OFF : L_FY);
        end
        btn = 1'b0;
        fm  = 1'b0;
        wait_lamps(L_RED, 6, "flash_exit", n);
        chk_int("flash_exit_lat", n, 3);
        step();
        chk("flash_arb2", L_RED);
        step();
        chk("post_flash_green", L_GRN);
        repeat (12) begin
            step();
            chk("no_req_after_flash", L_GRN);
        end

        // Reset mid PED_CLEAR acts without a clock edge.
        btn = 1'b1;
        repeat (6) step();
        btn = 1'b0;
        wait_lamps(L_PC0, 40, "to_ped_clear", n);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", L_RED);
        repeat (2) begin
            step();
            chk("rst_hold", L_RED);
        end
        rst_n = 1'b1;
        step();
        chk("rst_arb1", L_RED);
        step();
        chk("rst_green", L_GRN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pedestrian_xing.md
PEDESTRIAN_XING -- requirements
Module: pedestrian_xing

Interface
REQ-001 Parameter TIMER_SCALE, default 16000000: clock cycles per timing unit (1 s at 16 MHz; 1 for simulation).
REQ-002 Parameter T_GREEN_MIN, default 10: minimum car-green units before a request is served.
REQ-003 Parameter T_YELLOW, default 3: car-yellow units.
REQ-004 Parameter T_ALL_RED, default 2: all-red clearance units.
REQ-005 Parameter T_PED_GREEN, default 8: steady pedestrian-green units.
REQ-006 Parameter T_PED_CLEAR, default 4: flashing pedestrian-green units.
REQ-007 Parameter DB_CYCLES, default 160000: clock cycles a button level must be stable to be accepted.
REQ-008 i_pin3_clk_16mhz  in  1  sole clock; all state on its rising edge.
REQ-009 i_pin2_rst_n  in  1  asynchronous, active-low reset.
REQ-010 i_pin9_ped_button  in  1  asynchronous push-button, active-high.
REQ-011 i_pin10_flash_mode  in  1  asynchronous night-mode select, active-high.
REQ-012 o_pin4_green, o_pin5_yellow, o_pin6_red  out  1 each  car lamps.
REQ-013 o_pin7_ped_green, o_pin8_ped_red  out  1 each  pedestrian lamps.
REQ-014 o_pin11_wait_lamp  out  1  "request registered" indicator.

Function
REQ-015 Button and flash-mode inputs SHALL pass through 2-FF synchronisers before any use.
REQ-016 Synchronised button SHALL be debounced: the debounced level changes only after DB_CYCLES consecutive equal samples.
REQ-017 Each debounced 0->1 edge SHALL set a request latch; o_pin11_wait_lamp = latch, registered.
REQ-018 The request latch SHALL clear on entry to PED_GREEN and on entry to FLASH; edges occurring during FLASH SHALL be ignored.
REQ-019 States: ALL_RED_B (initial), CAR_GREEN, CAR_YELLOW, ALL_RED_A, PED_GREEN, PED_CLEAR, FLASH.
REQ-020 A prescaler SHALL emit a one-cycle tick every TIMER_SCALE cycles; the prescaler and phase counter restart at every state entry, so a state of N units lasts exactly N*TIMER_SCALE cycles.
REQ-021 Timed transitions: CAR_YELLOW (T_YELLOW) -> ALL_RED_A (T_ALL_RED) -> PED_GREEN (T_PED_GREEN) -> PED_CLEAR (T_PED_CLEAR) -> ALL_RED_B (T_ALL_RED) -> CAR_GREEN.
REQ-022 CAR_GREEN SHALL be exited only after phase count >= T_GREEN_MIN; the count saturates there.
REQ-023 In CAR_GREEN, synchronised flash_mode=1 SHALL force FLASH at the next cycle, with priority over a pending request and irrespective of T_GREEN_MIN.
REQ-024 In CAR_GREEN with flash_mode=0, a set latch and a satisfied minimum SHALL cause a transition to CAR_YELLOW.
REQ-025 FLASH with flash_mode=0 SHALL go to ALL_RED_B; flash_mode is ignored in all other states.
REQ-026 Lamps, registered and updated in the same cycle as the state: CAR_GREEN green+ped_red; CAR_YELLOW yellow+ped_red; ALL_RED_x red+ped_red; PED_GREEN red+ped_green; PED_CLEAR red with ped_green toggling each tick, starting at 1; FLASH yellow toggling each tick, starting at 1, all other lamps 0.
REQ-027 Car green and ped_green SHALL never be 1 simultaneously; ped_red and ped_green SHALL never be 1 simultaneously.
REQ-028 A request arriving during PED_GREEN, PED_CLEAR or ALL_RED_B SHALL stay latched and be served after the next full minimum green.

Reset
REQ-029 While i_pin2_rst_n=0: state ALL_RED_B, counters and prescaler 0, latch 0, debounced level 0, synchronisers 0, outputs red=1 and ped_red=1, all others 0.
REQ-030 Reset asserted mid-phase SHALL take effect immediately; after release the block runs ALL_RED_B for T_ALL_RED units, then enters CAR_GREEN.

Verification (TIMER_SCALE=1, DB_CYCLES=4, other parameters default)
REQ-031 Release reset, no button -> red/ped_red for 2 cycles, then green held indefinitely, wait_lamp=0.
REQ-032 Button held 6 cycles at green phase count 3 -> wait_lamp=1; yellow starts when the phase count reaches 10; then yellow 3, all-red 2, ped_green 8, ped flash 4 (1,0,1,0), all-red 2, green; wait_lamp clears at ped_green entry.
REQ-033 Button pulses of 3 cycles -> no request latched, wait_lamp stays 0.
REQ-034 Button pressed during PED_GREEN -> wait_lamp stays 1 through the clearance phases; the next yellow starts exactly 10 cycles after green re-entry.
REQ-035 flash_mode=1 with a pending request in CAR_GREEN -> FLASH, yellow toggles every cycle, ped lamps dark, wait_lamp=0; flash_mode=0 -> all-red 2 cycles -> green.
REQ-036 Reset pulsed during PED_CLEAR -> outputs immediately red=1 and ped_red=1; the lamp-exclusion assertions of REQ-027 hold across the whole run.
